// File: rtl/accum_block.sv
// Two-stage signed accumulate/subtract unit: an input register feeds an accumulator.
// Emits a framed block sum every BLOCK_LEN accumulations, with optional saturation and a sticky overflow flag.
module accum_block #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 12,
  parameter int BLOCK_LEN = 16,
  parameter int SATURATE  = 1
) (
  input  logic                 clk_sys,
  input  logic                 rst_sys,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sub,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 blk_valid,
  output logic [ACC_WIDTH-1:0] blk_sum,
  output logic                 ovf
);

  localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(BLOCK_LEN - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]     r_s1_data;
  logic                 r_s1_sub;
  logic                 r_s1_vld;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_blk_valid;
  logic [ACC_WIDTH-1:0] r_blk_sum;
  logic                 r_ovf;

  logic signed [ACC_WIDTH:0] w_acc_ext;
  logic signed [ACC_WIDTH:0] w_smp_ext;
  logic signed [ACC_WIDTH:0] w_nxt;
  logic                      w_ovf;
  logic [ACC_WIDTH-1:0]      w_res;
  logic                      w_last;

  // One guard bit is enough: |acc| and |sample| are both bounded by 2^(ACC_WIDTH-1).
  assign w_acc_ext = {r_acc[ACC_WIDTH-1], r_acc};
  assign w_smp_ext = (ACC_WIDTH+1)'($signed(r_s1_data));
  assign w_nxt     = r_s1_sub ? (w_acc_ext - w_smp_ext) : (w_acc_ext + w_smp_ext);
  assign w_ovf     = (w_nxt[ACC_WIDTH] != w_nxt[ACC_WIDTH-1]);
  assign w_last    = (r_cnt == CNT_LAST);

  always_comb begin
    w_res = w_nxt[ACC_WIDTH-1:0];
    if (w_ovf && (SATURATE != 0)) begin
      w_res = w_nxt[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      r_s1_data   <= '0;
      r_s1_sub    <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_blk_valid <= 1'b0;
      r_blk_sum   <= '0;
      r_ovf       <= 1'b0;
    end else if (clear) begin
      // blk_sum deliberately survives a clear so the last framed result stays readable.
      r_s1_vld    <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_blk_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_s1_vld    <= in_valid;
      r_blk_valid <= 1'b0;
      if (in_valid) begin
        r_s1_data <= in_data;
        r_s1_sub  <= in_sub;
      end
      if (r_s1_vld) begin
        if (w_last) begin
          r_blk_sum   <= w_res;
          r_blk_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_ovf       <= w_ovf;
        end else begin
          r_acc <= w_res;
          r_cnt <= r_cnt + CNT_W'(1);
          r_ovf <= r_ovf | w_ovf;
        end
      end
    end
  end

  assign acc_o     = r_acc;
  assign blk_valid = r_blk_valid;
  assign blk_sum   = r_blk_sum;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_accum_block.sv
// Scoreboard bench for accum_block: bus A drives a BLOCK_LEN=4 saturating unit,
// bus S drives saturating/wrapping BLOCK_LEN=32 units and a BLOCK_LEN=1 unit in parallel.
module tb_accum_block;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int acc;
    bit ovf;
    bit blk;
    int sum;
  } exp_t;

  exp_t qa[$];
  exp_t qs[$];
  exp_t qw[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_errors = 0;

  logic        a_rst = 1'b1, a_valid = 1'b0, a_sub = 1'b0, a_clear = 1'b0;
  logic [7:0]  a_data = 8'd0;
  logic [11:0] a_acc, a_bs;
  logic        a_bv, a_ovf;

  logic        s_rst = 1'b1, s_valid = 1'b0, s_sub = 1'b0, s_clear = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic [11:0] sat_acc, sat_bs, wrp_acc, wrp_bs, one_acc, one_bs;
  logic        sat_bv, sat_ovf, wrp_bv, wrp_ovf, one_bv, one_ovf;

  accum_block #(.WIDTH(8), .ACC_WIDTH(12), .BLOCK_LEN(4), .SATURATE(1)) u_a (
    .clk_sys(clk_sys), .rst_sys(a_rst), .in_valid(a_valid), .in_data(a_data), .in_sub(a_sub),
    .clear(a_clear), .acc_o(a_acc), .blk_valid(a_bv), .blk_sum(a_bs), .ovf(a_ovf));

  accum_block #(.WIDTH(8), .ACC_WIDTH(12), .BLOCK_LEN(32), .SATURATE(1)) u_sat (
    .clk_sys(clk_sys), .rst_sys(s_rst), .in_valid(s_valid), .in_data(s_data), .in_sub(s_sub),
    .clear(s_clear), .acc_o(sat_acc), .blk_valid(sat_bv), .blk_sum(sat_bs), .ovf(sat_ovf));

  accum_block #(.WIDTH(8), .ACC_WIDTH(12), .BLOCK_LEN(32), .SATURATE(0)) u_wrp (
    .clk_sys(clk_sys), .rst_sys(s_rst), .in_valid(s_valid), .in_data(s_data), .in_sub(s_sub),
    .clear(s_clear), .acc_o(wrp_acc), .blk_valid(wrp_bv), .blk_sum(wrp_bs), .ovf(wrp_ovf));

  accum_block #(.WIDTH(8), .ACC_WIDTH(12), .BLOCK_LEN(1), .SATURATE(1)) u_one (
    .clk_sys(clk_sys), .rst_sys(s_rst), .in_valid(s_valid), .in_data(s_data), .in_sub(s_sub),
    .clear(s_clear), .acc_o(one_acc), .blk_valid(one_bv), .blk_sum(one_bs), .ovf(one_ovf));

  function automatic void check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void cmp(input string nm, input exp_t e, input int acc, input int ov,
                              input int bv, input int bs);
    check({nm, " acc_o"}, acc, e.acc);
    check({nm, " ovf"}, ov, int'(e.ovf));
    check({nm, " blk_valid"}, bv, int'(e.blk));
    if (e.blk) check({nm, " blk_sum"}, bs, e.sum);
  endfunction

  function automatic exp_t mk(input int acc, input bit ov, input bit blk, input int sum);
    exp_t e;
    e.acc = acc; e.ovf = ov; e.blk = blk; e.sum = sum;
    return e;
  endfunction

  function automatic void missing(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got an accumulation expected none queued", nm);
  endfunction

  // Monitors track only which driven samples survive clear/reset, then compare against the queue.
  bit a_v1 = 0, a_v2 = 0, s_v1 = 0, s_v2 = 0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk_sys);
      if (a_rst) begin a_v1 = 0; a_v2 = 0; end
      else begin a_v2 = a_v1 & ~a_clear; a_v1 = a_valid & ~a_clear; end
      #1;
      if (a_v2) begin
        if (qa.size() == 0) missing("a_sb");
        else begin
          e = qa.pop_front();
          cmp("a", e, $signed(a_acc), a_ovf, a_bv, $signed(a_bs));
        end
      end else check("a idle blk_valid", a_bv, 0);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk_sys);
      if (s_rst) begin s_v1 = 0; s_v2 = 0; end
      else begin s_v2 = s_v1 & ~s_clear; s_v1 = s_valid & ~s_clear; end
      #1;
      if (s_v2) begin
        if (qs.size() == 0) missing("sat_sb");
        else begin e = qs.pop_front(); cmp("sat", e, $signed(sat_acc), sat_ovf, sat_bv, $signed(sat_bs)); end
        if (qw.size() == 0) missing("wrp_sb");
        else begin e = qw.pop_front(); cmp("wrp", e, $signed(wrp_acc), wrp_ovf, wrp_bv, $signed(wrp_bs)); end
        if (q1.size() == 0) missing("one_sb");
        else begin e = q1.pop_front(); cmp("one", e, $signed(one_acc), one_ovf, one_bv, $signed(one_bs)); end
      end else begin
        check("sat idle blk_valid", sat_bv, 0);
        check("one idle blk_valid", one_bv, 0);
      end
    end
  end

  task automatic a_drv(input bit v, input int d, input bit s, input bit c);
    @(negedge clk_sys);
    a_valid = v; a_data = 8'(d); a_sub = s; a_clear = c;
  endtask

  task automatic s_drv(input bit v, input int d, input bit s, input bit c);
    @(negedge clk_sys);
    s_valid = v; s_data = 8'(d); s_sub = s; s_clear = c;
  endtask

  task automatic run_a();
    repeat (3) @(negedge clk_sys);
    check("a reset acc_o", $signed(a_acc), 0);
    check("a reset blk_valid", a_bv, 0);
    check("a reset blk_sum", $signed(a_bs), 0);
    check("a reset ovf", a_ovf, 0);
    a_rst = 1'b0;

    // Two blocks back to back: plain adds, then mixed add/subtract including -(-128).
    qa.push_back(mk(10, 0, 0, 0));  qa.push_back(mk(30, 0, 0, 0));
    qa.push_back(mk(60, 0, 0, 0));  qa.push_back(mk(0, 0, 1, 100));
    qa.push_back(mk(50, 0, 0, 0));  qa.push_back(mk(178, 0, 0, 0));
    qa.push_back(mk(148, 0, 0, 0)); qa.push_back(mk(0, 0, 1, 143));
    a_drv(1, 10, 0, 0); a_drv(1, 20, 0, 0); a_drv(1, 30, 0, 0); a_drv(1, 40, 0, 0);
    a_drv(1, 50, 0, 0); a_drv(1, -128, 1, 0); a_drv(1, 30, 1, 0); a_drv(1, -5, 0, 0);
    a_drv(0, 0, 0, 0);

    // Clear mid-block drops the partial sum and the sample offered with it.
    qa.push_back(mk(5, 0, 0, 0)); qa.push_back(mk(10, 0, 0, 0));
    a_drv(1, 5, 0, 0); a_drv(1, 5, 0, 0); a_drv(0, 0, 0, 0);
    a_drv(1, 5, 0, 1); a_drv(0, 0, 0, 0);
    #1;
    check("a clear acc_o", $signed(a_acc), 0);
    check("a clear keeps blk_sum", $signed(a_bs), 143);
    check("a clear ovf", a_ovf, 0);
    qa.push_back(mk(7, 0, 0, 0));  qa.push_back(mk(14, 0, 0, 0));
    qa.push_back(mk(21, 0, 0, 0)); qa.push_back(mk(0, 0, 1, 28));
    repeat (4) a_drv(1, 7, 0, 0);
    repeat (3) a_drv(0, 0, 0, 0);
    #1;
    check("a blk_sum holds", $signed(a_bs), 28);

    // Asynchronous reset mid-cycle with a sample sitting in stage 1.
    qa.push_back(mk(10, 0, 0, 0)); qa.push_back(mk(30, 0, 0, 0)); qa.push_back(mk(60, 0, 0, 0));
    a_drv(1, 10, 0, 0); a_drv(1, 20, 0, 0); a_drv(1, 30, 0, 0); a_drv(1, 40, 0, 0);
    @(negedge clk_sys);
    #1 a_rst = 1'b1;
    #1;
    check("a async rst acc_o", $signed(a_acc), 0);
    check("a async rst blk_valid", a_bv, 0);
    check("a async rst blk_sum", $signed(a_bs), 0);
    check("a async rst ovf", a_ovf, 0);
    @(negedge clk_sys);
    a_valid = 1'b0;
    #1 a_rst = 1'b0;
    qa.push_back(mk(1, 0, 0, 0)); qa.push_back(mk(2, 0, 0, 0));
    qa.push_back(mk(3, 0, 0, 0)); qa.push_back(mk(0, 0, 1, 4));
    repeat (4) a_drv(1, 1, 0, 0);
    repeat (3) a_drv(0, 0, 0, 0);
  endtask

  task automatic run_s();
    repeat (3) @(negedge clk_sys);
    s_rst = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      qs.push_back(mk(127 * n, 0, 0, 0));
      qw.push_back(mk(127 * n, 0, 0, 0));
      q1.push_back(mk(0, 0, 1, 127));
    end
    // 17th: 2159 is out of range -> clamp 2047 / wrap -1937; 18th shows ovf is sticky.
    qs.push_back(mk(2047, 1, 0, 0));  qw.push_back(mk(-1937, 1, 0, 0)); q1.push_back(mk(0, 0, 1, 127));
    qs.push_back(mk(2047, 1, 0, 0));  qw.push_back(mk(-1810, 1, 0, 0)); q1.push_back(mk(0, 0, 1, 127));
    qs.push_back(mk(1919, 1, 0, 0));  qw.push_back(mk(-1938, 1, 0, 0)); q1.push_back(mk(0, 0, 1, -128));
    repeat (18) s_drv(1, 127, 0, 0);
    s_drv(1, -128, 0, 0);
    repeat (2) s_drv(0, 0, 0, 0);

    s_drv(0, 0, 0, 1); s_drv(0, 0, 0, 0);
    #1;
    check("sat clear acc_o", $signed(sat_acc), 0);
    check("sat clear ovf", sat_ovf, 0);
    check("wrp clear acc_o", $signed(wrp_acc), 0);
    check("wrp clear ovf", wrp_ovf, 0);
    check("one clear keeps blk_sum", $signed(one_bs), -128);

    qs.push_back(mk(128, 0, 0, 0)); qw.push_back(mk(128, 0, 0, 0)); q1.push_back(mk(0, 0, 1, 128));
    s_drv(1, -128, 1, 0);
    repeat (3) s_drv(0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      run_a();
      run_s();
    join
    repeat (3) @(negedge clk_sys);
    check("qa drained", qa.size(), 0);
    check("qs drained", qs.size(), 0);
    check("qw drained", qw.size(), 0);
    check("q1 drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/accum_block.md
Name: accum_block

Overview:
Parametrised signed accumulate/subtract unit: the next-generation replacement for the fixed 8-bit register/add-subtract/register accumulator loop. It keeps the same two-stage structure (input register, then accumulator register), and adds:
- parametrised widths
- per-sample add/subtract select
- valid qualification
- optional saturation with sticky overflow
- synchronous clear
- block mode that emits a framed sum every BLOCK_LEN samples

It sits between a sample source and downstream datapath logic on the clk_sys domain.

Parameters:
WIDTH, 8, input sample width (two's complement)
ACC_WIDTH, 12, accumulator/result width (two's complement), must be >= WIDTH
BLOCK_LEN, 16, samples per block (>= 1)
SATURATE, 1, 1 = clamp at ACC_WIDTH signed limits; 0 = wrap modulo 2^ACC_WIDTH

Ports:
clk_sys  input  1  system clock, all state on rising edge
rst_sys  input  1  asynchronous reset, active-high
in_valid  input  1  qualifies in_data/in_sub this cycle
in_data  input  WIDTH  signed sample
in_sub  input  1  1 = subtract sample, 0 = add
clear  input  1  synchronous clear of pipeline, accumulator, counter, flags
acc_o  output  ACC_WIDTH  running accumulator value
blk_valid  output  1  one-cycle pulse: blk_sum holds a completed block
blk_sum  output  ACC_WIDTH  final sum of last completed block
ovf  output  1  sticky: overflow/saturation occurred since last clear/reset or last block boundary

Behaviour:
- Reset: asynchronous, active-high; while rst_sys=1 all registers are 0 (s1_data, s1_sub, s1_vld, acc_o, cnt, blk_valid, blk_sum, ovf). Release mid-operation restarts at an empty block; samples in stage 1 are lost.
- Stage 1, every edge: s1_vld<=in_valid; if in_valid, s1_data<=in_data and s1_sub<=in_sub.
- Stage 2, when s1_vld=1:
  - Compute nxt = acc_o ± sign_extend(s1_data), evaluated at ACC_WIDTH+1 bits.
  - Overflow is when nxt is outside [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - SATURATE=1: clamp to the nearest limit. SATURATE=0: take the low ACC_WIDTH bits.
  - On overflow, set ovf.
- Latency: a sample presented at edge k is in stage 1 after edge k and is reflected in acc_o after edge k+1. Back-to-back valids are accepted every cycle with no stall; there is no backpressure.
- When s1_vld=0, acc_o, cnt and ovf hold.
- Block counter cnt (width clog2(BLOCK_LEN), min 1) increments on each stage-2 accumulation.
- Block boundary: a stage-2 accumulation with cnt==BLOCK_LEN-1. On that edge:
  - blk_sum<=final saturated/wrapped value; blk_valid<=1 for exactly one cycle.
  - acc_o<=0 and cnt<=0, so the next sample starts a fresh block.
  - ovf<=0, unless this final sample itself overflowed; then ovf<=1.
- A boundary accumulation (the block's last sample) and a new in_valid on the same edge are both handled: stage 1 captures the new sample, which becomes the first sample of the next block.
- blk_sum holds until the next boundary. blk_valid=0 on all other cycles.
- clear=1 (synchronous, priority over all non-reset updates):
  - s1_vld, acc_o, cnt, ovf, blk_valid <= 0; blk_sum holds.
  - in_valid on a clear cycle is discarded.
- BLOCK_LEN=1: every valid sample produces blk_valid with blk_sum = ±sample (saturated); acc_o always returns to 0.
- Subtracting the most negative WIDTH value is exact, since ACC_WIDTH >= WIDTH and the arithmetic is extended by 1 bit.

Test Plan:
1. WIDTH=8, ACC_WIDTH=12, BLOCK_LEN=4; valid add 10,20,30,40 on consecutive cycles.
   -> acc_o = 10,30,60 on the 2nd-4th edges after the first sample. On the next edge: blk_valid=1 for 1 cycle, blk_sum=100, acc_o=0, ovf=0.
2. Mixed ops, BLOCK_LEN=4: add 50, sub -128, sub 30, add -5.
   -> blk_sum = 50+128-30-5 = 143.
3. SATURATE=1, BLOCK_LEN=32: add 127 seventeen times.
   -> acc_o reaches 2032 after 16 samples; the 17th sample gives acc_o=2047 and ovf=1, which stays 1 on further adds.
   -> Then add -128: acc_o=1919, ovf still 1.
4. SATURATE=0, same stimulus as scenario 3.
   -> the 17th sample gives acc_o = 2159-4096 = -1937, ovf=1.
5. BLOCK_LEN=4: add 5,5; assert clear in the same cycle as a third valid 5; then add 7,7,7,7.
   -> acc_o=0 after clear and the third 5 is dropped. blk_valid pulses with blk_sum=28; the earlier blk_sum value is unaffected by clear.
6. Accumulate to acc_o=60; pulse rst_sys asynchronously mid-cycle with in_valid=1.
   -> all outputs 0 immediately. After release, add 1 x4 (BLOCK_LEN=4) -> blk_sum=4.
